// File: rtl/ppe_rr_scheduler.sv
// ppe_rr_scheduler
// ----------------
// Round-robin grant scheduler that drives an external N-bit programmable
// priority encoder (PPE). Requests seen while idle are snapshotted into the
// PPE request vector together with the current round-robin pointer. After
// the PPE pipeline has settled, the winning index is offered on a
// valid/ready grant port. Each accepted grant moves the pointer to
// winner+1, so priority rotates fairly across all requesters.
//
// Ports:
//   clk             clock
//   rst             asynchronous reset, active-low
//   req_i           level request lines, bit i = requester i
//   cfg_ptr_load    pulse: overwrite the round-robin pointer with cfg_ptr
//   cfg_ptr         pointer value used with cfg_ptr_load
//   ppe_req         registered request snapshot to the PPE Req input
//   ppe_p_enc       registered pointer to the PPE P_enc input
//   ppe_value       PPE o_value (winning index)
//   ppe_value_inc   PPE o_value_inc (winner+1, mod N)
//   ppe_valid       PPE valid (snapshot had at least one request)
//   gnt_valid       grant available
//   gnt_ready       grant consumer accepts
//   gnt_idx         granted requester index
//   busy            high whenever an arbitration is in progress
//   stat_grant_cnt  saturating accepted-grant counter (0 when disabled)
//
// Optional feature macro: PPE_RR_STATS_EN
//   defined   -> stat_grant_cnt counts accepted grants, saturating
//   undefined -> stat_grant_cnt is tied to 0

module ppe_rr_scheduler #(
    parameter int N       = 512,
    parameter int IDX_W   = 9,
    parameter int PPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             cfg_ptr_load,
    input  logic [IDX_W-1:0] cfg_ptr,
    output logic [N-1:0]     ppe_req,
    output logic [IDX_W-1:0] ppe_p_enc,
    input  logic [IDX_W-1:0] ppe_value,
    input  logic [IDX_W-1:0] ppe_value_inc,
    input  logic             ppe_valid,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic [31:0]      stat_grant_cnt
);

    localparam int CNT_W = $clog2(PPE_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] nxt_ptr;
    logic             capture;
    logic             wait_done;
    logic             accept;

    // State register. Reset abandons any in-flight arbitration, so no
    // grant can emerge from a snapshot taken before reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the per-cycle event strobes used by the
    // datapath. wait_done fires once the PPE has had PPE_LAT full cycles
    // to settle on the held snapshot. If the PPE reports no winner the
    // scheduler simply falls back to IDLE without issuing a grant.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        wait_done = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (|req_i) begin
                    capture   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    wait_done = ppe_valid;
                    state_nxt = ppe_valid ? GRANT : IDLE;
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Snapshot and wait-counter registers. The PPE inputs only change on a
    // capture, so they stay frozen through WAIT and GRANT and later changes
    // on req_i cannot disturb the in-flight grant. Outside a capture they
    // keep their previous values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ppe_req   <= '0;
            ppe_p_enc <= '0;
            cnt       <= '0;
        end else begin
            if (capture) begin
                ppe_req   <= req_i;
                ppe_p_enc <= ptr;
                cnt       <= CNT_W'(PPE_LAT);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Grant output registers. The winner and its successor pointer are
    // latched together when the PPE result is taken, and the grant is held
    // until the consumer accepts it. gnt_ready outside GRANT has no effect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            nxt_ptr   <= '0;
        end else begin
            if (wait_done) begin
                gnt_valid <= 1'b1;
                gnt_idx   <= ppe_value;
                nxt_ptr   <= ppe_value_inc;
            end else if (accept) begin
                gnt_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer. A configuration load is honoured in any state
    // and takes precedence over the post-grant advance when both land on
    // the same edge. The pointer wraps naturally in IDX_W bits; the PPE
    // itself performs the circular search from this position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else begin
            if (cfg_ptr_load) begin
                ptr <= cfg_ptr;
            end else if (accept) begin
                ptr <= nxt_ptr;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef PPE_RR_STATS_EN
    // Accepted-grant statistics counter, holding at all-ones rather than
    // wrapping so a long run never reports a misleadingly small count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grant_cnt <= '0;
        end else begin
            if (accept && stat_grant_cnt != 32'hFFFF_FFFF) begin
                stat_grant_cnt <= stat_grant_cnt + 32'd1;
            end
        end
    end
`else
    assign stat_grant_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ppe_rr_scheduler.sv
// tb_ppe_rr_scheduler
// -------------------
// Self-checking bench for ppe_rr_scheduler. A behavioural PPE (circular
// first-set search from P_enc, delayed by PPE_LAT cycles) feeds the DUT.
// Expected grants, pointer values and timing come from a reference model
// of the round-robin rules: winner = first requester at or after the
// pointer (circularly), pointer = winner+1 after each accepted grant,
// unless a pointer load lands on the same edge.

module tb_ppe_rr_scheduler;

    localparam int N       = 512;
    localparam int IDX_W   = 9;
    localparam int PPE_LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_i;
    logic             cfg_ptr_load;
    logic [IDX_W-1:0] cfg_ptr;
    logic [N-1:0]     ppe_req;
    logic [IDX_W-1:0] ppe_p_enc;
    logic [IDX_W-1:0] ppe_value;
    logic [IDX_W-1:0] ppe_value_inc;
    logic             ppe_valid;
    logic             gnt_valid;
    logic             gnt_ready;
    logic [IDX_W-1:0] gnt_idx;
    logic             busy;
    logic [31:0]      stat_grant_cnt;

    int pass_count  = 0;
    int check_count = 0;
    int fail_count  = 0;

    int               ref_ptr;
    int               grant_total;
    logic [N-1:0]     dir_req;
    logic [N-1:0]     rand_req;
    logic [N-1:0]     rand_after;

    ppe_rr_scheduler #(
        .N       (N),
        .IDX_W   (IDX_W),
        .PPE_LAT (PPE_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .cfg_ptr_load   (cfg_ptr_load),
        .cfg_ptr        (cfg_ptr),
        .ppe_req        (ppe_req),
        .ppe_p_enc      (ppe_p_enc),
        .ppe_value      (ppe_value),
        .ppe_value_inc  (ppe_value_inc),
        .ppe_valid      (ppe_valid),
        .gnt_valid      (gnt_valid),
        .gnt_ready      (gnt_ready),
        .gnt_idx        (gnt_idx),
        .busy           (busy),
        .stat_grant_cnt (stat_grant_cnt)
    );

    always #5 clk = ~clk;

    // Circular first-set search starting at position p.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) begin
                return (p + k) % N;
            end
        end
        return 0;
    endfunction

    // Behavioural PPE: inputs pass through a PPE_LAT-deep delay line, so
    // the outputs show the previous snapshot until the new one has settled.
    logic [N-1:0]     req_pipe [PPE_LAT];
    logic [IDX_W-1:0] ptr_pipe [PPE_LAT];
    int               ppe_win;

    initial begin
        for (int s = 0; s < PPE_LAT; s++) begin
            req_pipe[s] = '0;
            ptr_pipe[s] = '0;
        end
    end

    always @(posedge clk) begin
        req_pipe[0] <= ppe_req;
        ptr_pipe[0] <= ppe_p_enc;
        for (int s = 1; s < PPE_LAT; s++) begin
            req_pipe[s] <= req_pipe[s-1];
            ptr_pipe[s] <= ptr_pipe[s-1];
        end
    end

    always_comb begin
        ppe_win       = rr_pick(req_pipe[PPE_LAT-1], int'(ptr_pipe[PPE_LAT-1]));
        ppe_valid     = |req_pipe[PPE_LAT-1];
        ppe_value     = IDX_W'(ppe_win);
        ppe_value_inc = IDX_W'((ppe_win + 1) % N);
    end

    function automatic logic [31:0] exp_stat();
`ifdef PPE_RR_STATS_EN
        return 32'(grant_total);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [N-1:0] make_req();
        logic [N-1:0] r;
        logic [N-1:0] m;
        int           mode;
        for (int w = 0; w < N / 32; w++) begin
            r[w*32 +: 32] = $urandom;
            m[w*32 +: 32] = $urandom & $urandom;
        end
        mode = $urandom_range(0, 2);
        if (mode == 1) begin
            r = r & m;
        end else if (mode == 2) begin
            r = '0;
            r[$urandom_range(0, N-1)] = 1'b1;
        end
        if (r == '0) begin
            r[$urandom_range(0, N-1)] = 1'b1;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                               input logic [N-1:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full arbitration: present reqs while idle, follow the snapshot
    // through the PPE wait, hold the grant for ready_delay cycles with
    // req_i switched to req_after, then accept (optionally loading the
    // pointer on the accept edge). Leaves the DUT idle at a falling edge.
    task automatic applyStimulus(input logic [N-1:0] reqs, input int ready_delay,
                                 input logic [N-1:0] req_after,
                                 input bit load_at_accept, input int load_val);
        int exp_win;
        exp_win   = rr_pick(reqs, ref_ptr);
        req_i     = reqs;
        gnt_ready = 1'b0;
        @(negedge clk);
        checkOutput("cap_ppe_req", ppe_req, reqs);
        checkOutput("cap_p_enc", N'(ppe_p_enc), N'(ref_ptr));
        checkOutput("cap_busy", N'(busy), N'(1));
        req_i     = req_after;
        gnt_ready = 1'($urandom_range(0, 1));
        for (int k = 1; k <= PPE_LAT; k++) begin
            checkOutput("wait_gnt_valid", N'(gnt_valid), N'(0));
            @(negedge clk);
        end
        checkOutput("wait_gnt_valid", N'(gnt_valid), N'(0));
        checkOutput("wait_p_enc_held", N'(ppe_p_enc), N'(ref_ptr));
        gnt_ready = 1'b0;
        @(negedge clk);
        checkOutput("gnt_valid_rise", N'(gnt_valid), N'(1));
        checkOutput("gnt_idx", N'(gnt_idx), N'(exp_win));
        for (int d = 0; d < ready_delay; d++) begin
            @(negedge clk);
            checkOutput("hold_gnt_valid", N'(gnt_valid), N'(1));
            checkOutput("hold_gnt_idx", N'(gnt_idx), N'(exp_win));
        end
        gnt_ready    = 1'b1;
        cfg_ptr_load = load_at_accept;
        cfg_ptr      = IDX_W'(load_val);
        @(negedge clk);
        grant_total++;
        ref_ptr = load_at_accept ? load_val : (exp_win + 1) % N;
        checkOutput("accept_gnt_valid", N'(gnt_valid), N'(0));
        checkOutput("accept_busy", N'(busy), N'(0));
        checkOutput("stat_grant_cnt", N'(stat_grant_cnt), N'(exp_stat()));
        gnt_ready    = 1'b0;
        cfg_ptr_load = 1'b0;
        req_i        = '0;
    endtask

    task automatic loadPtr(input int v);
        cfg_ptr_load = 1'b1;
        cfg_ptr      = IDX_W'(v);
        @(negedge clk);
        cfg_ptr_load = 1'b0;
        ref_ptr      = v;
        checkOutput("load_busy", N'(busy), N'(0));
    endtask

    initial begin
        rst          = 1'b0;
        req_i        = '0;
        cfg_ptr_load = 1'b0;
        cfg_ptr      = '0;
        gnt_ready    = 1'b0;
        ref_ptr      = 0;
        grant_total  = 0;

        repeat (3) @(negedge clk);
        checkOutput("rst_gnt_valid", N'(gnt_valid), N'(0));
        checkOutput("rst_busy", N'(busy), N'(0));
        checkOutput("rst_ppe_req", ppe_req, '0);
        checkOutput("rst_p_enc", N'(ppe_p_enc), N'(0));
        checkOutput("rst_gnt_idx", N'(gnt_idx), N'(0));
        checkOutput("rst_stat", N'(stat_grant_cnt), N'(0));
        rst = 1'b1;

        $display("[TB] idle with no requests");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("idle_busy", N'(busy), N'(0));
            checkOutput("idle_gnt_valid", N'(gnt_valid), N'(0));
            checkOutput("idle_ppe_req", ppe_req, '0);
        end

        $display("[TB] rotating grants over requesters 0,2,5");
        dir_req = '0;
        dir_req[6:0] = 7'b0100101;
        applyStimulus(dir_req, 0, dir_req, 1'b0, 0);
        checkOutput("seq_ptr_after_0", N'(ref_ptr), N'(1));
        applyStimulus(dir_req, 0, dir_req, 1'b0, 0);
        applyStimulus(dir_req, 0, dir_req, 1'b0, 0);
        checkOutput("seq_ptr_after_5", N'(ref_ptr), N'(6));
        applyStimulus(dir_req, 0, dir_req, 1'b0, 0);

        $display("[TB] pointer load to 5, then wrap");
        loadPtr(5);
        applyStimulus(dir_req, 0, dir_req, 1'b0, 0);
        applyStimulus(dir_req, 0, dir_req, 1'b0, 0);

        $display("[TB] pointer load coinciding with accept");
        applyStimulus(dir_req, 1, dir_req, 1'b1, 2);
        applyStimulus(dir_req, 0, dir_req, 1'b0, 0);

        $display("[TB] all requesters, pointer 511");
        loadPtr(511);
        applyStimulus('1, 0, '1, 1'b0, 0);
        applyStimulus('1, 0, '1, 1'b0, 0);

        $display("[TB] grant held 8 cycles with requests dropped");
        applyStimulus(dir_req, 8, '0, 1'b0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("post_hold_busy", N'(busy), N'(0));
            checkOutput("post_hold_gnt_valid", N'(gnt_valid), N'(0));
        end

        $display("[TB] reset during WAIT");
        dir_req = '0;
        dir_req[0] = 1'b1;
        dir_req[3] = 1'b1;
        req_i = '1;
        @(negedge clk);
        checkOutput("pre_rst_busy", N'(busy), N'(1));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_busy", N'(busy), N'(0));
        checkOutput("mid_rst_gnt_valid", N'(gnt_valid), N'(0));
        checkOutput("mid_rst_ppe_req", ppe_req, '0);
        checkOutput("mid_rst_p_enc", N'(ppe_p_enc), N'(0));
        checkOutput("mid_rst_stat", N'(stat_grant_cnt), N'(0));
        req_i = '0;
        ref_ptr = 0;
        grant_total = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("rst_hold_gnt_valid", N'(gnt_valid), N'(0));
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("after_rst_gnt_valid", N'(gnt_valid), N'(0));
        end
        applyStimulus(dir_req, 0, dir_req, 1'b0, 0);
        applyStimulus(dir_req, 0, dir_req, 1'b0, 0);

        $display("[TB] randomized arbitration");
        for (int t = 0; t < 40; t++) begin
            rand_req   = make_req();
            rand_after = ($urandom_range(0, 1) == 1) ? make_req() : '0;
            if ($urandom_range(0, 7) == 0) begin
                loadPtr($urandom_range(0, N-1));
            end
            applyStimulus(rand_req, $urandom_range(0, 3), rand_after,
                          ($urandom_range(0, 5) == 0), $urandom_range(0, N-1));
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
